alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
Shares the single 16-bit ALU (a, b, op, rst -> Y, flag) between up to NREQ requesters, e.g. the datapath control unit and the VGA debug/overlay logic.
- Arbitration is round-robin.
- Each accepted operation is latched and issued to the ALU for one cycle.
- The result is registered and returned with a valid/ready response handshake.
- Sits between the requesters and the ALU instance; the ALU itself is unchanged.

Parameters:
DATA_W, 16, operand/result width (matches ALU a, b, Y).
OP_W, 4, ALU opcode width.
NREQ, 2, number of requesters; legal range 2..4.
ID_W, 2, width of requester index; must satisfy 2**ID_W >= NREQ.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  NREQ  per-requester operation request.
req_ready  output  NREQ  one-hot accept pulse; the request is consumed in the cycle valid&ready.
req_a  input  NREQ*DATA_W  flattened operand A; requester i at bits [i*DATA_W +: DATA_W].
req_b  input  NREQ*DATA_W  flattened operand B, same packing.
req_op  input  NREQ*OP_W  flattened opcode, packed the same way.
rsp_valid  output  1  result available.
rsp_ready  input  1  consumer accepts the result.
rsp_id  output  ID_W  index of the requester that owns the result.
rsp_y  output  DATA_W  registered ALU Y.
rsp_flag  output  1  registered ALU flag.
alu_a  output  DATA_W  to ALU a.
alu_b  output  DATA_W  to ALU b.
alu_op  output  OP_W  to ALU op.
alu_rst  output  1  to ALU rst; equals rst, combinational.
alu_y  input  DATA_W  from ALU Y; combinational result.
alu_flag  input  1  from ALU flag.
busy  output  1  high whenever state != IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP; 2-bit encoding from the package.
- Reset (rst=1 at an edge):
  - state=IDLE, rr_ptr=0.
  - Operand/op registers cleared to 0; rsp_y=0, rsp_flag=0, rsp_id=0.
  - rsp_valid=0, req_ready=0, busy=0.
- Reset mid-operation aborts the operation. The latched request is dropped and no response is produced; requesters must re-request.
- IDLE, no req_valid bits set: stay in IDLE; req_ready=0.
- IDLE, any req_valid set:
  - Choose the first set bit starting at rr_ptr, wrapping NREQ-1 -> 0.
  - req_ready is combinational one-hot for the chosen index in this cycle only.
  - Latch that requester's a, b, op and its id; go to EXEC.
- EXEC (exactly 1 cycle):
  - alu_a/alu_b/alu_op are driven from the latched registers; they are 0 in every other state.
  - At the edge: rsp_y<=alu_y, rsp_flag<=alu_flag, rsp_id<=latched id, rsp_valid<=1; go to RESP.
- RESP: hold rsp_valid and the rsp_* values stable until rsp_valid&rsp_ready.
  - On that edge: rsp_valid<=0, rr_ptr<=(granted id+1) mod NREQ, go to IDLE.
  - No new request is accepted while in EXEC or RESP.
- Timing:
  - Latency: accept in cycle N -> rsp_valid first high in cycle N+2.
  - Best-case throughput: one operation per 3 cycles when rsp_ready is held high.
- Opcodes are opaque; any OP_W value is forwarded to the ALU unchanged.
- Round-robin guarantees that a continuously requesting client is granted within NREQ grants.
- Requesters must hold a, b and op stable while valid is high and not yet accepted.

Decomposition:
- Package alu_arb_pkg:
  - FSM state constants S_IDLE=2'd0, S_EXEC=2'd1, S_RESP=2'd2.
  - Default width constants DATA_W_DEF=16, OP_W_DEF=4.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[NREQ], ptr[ID_W].
  - Outputs: gnt_onehot[NREQ], gnt_id[ID_W], any.
  - Instantiated once.
- The FSM, latches and response register stay in alu_arbiter.

Test Plan:
1. Single request, real ALU instantiated. Req0 with op=4'b0101, a=15, b=11, rsp_ready=1.
   - req_ready[0] pulses in cycle N; rsp_valid high at N+2 with rsp_id=0.
   - rsp_y/rsp_flag equal to a direct ALU instance driven with the same a, b, op.
2. Simultaneous contention from reset (rr_ptr=0). Req0 op=4'b0110 a=15 b=11; req1 op=4'b0001 a=15 b=11; both held valid.
   - Grant order 0,1,0,1; each rsp_id matches the grant.
   - Results match the reference-instance values per op.
3. Backpressure. Req1 op=4'b0111 a=15 b=11, rsp_ready=0 for 5 cycles.
   - rsp_valid, rsp_y and rsp_id stable for 5 cycles; req_ready stays 0 even with req0 valid.
   - After rsp_ready=1, req0 is granted 1 cycle later.
4. Wrap-around, NREQ=3. Only req2 valid, then req0 and req2 valid together.
   - After serving 2, rr_ptr=0 and req0 is granted before req2.
5. Reset mid-operation. Assert rst for 1 cycle while in EXEC.
   - No rsp_valid, and all outputs are 0 the cycle after.
   - A held request is re-accepted once rst=0.
6. Idle quiet. No req_valid for 10 cycles.
   - busy=0, req_ready=0 and alu_a/alu_b/alu_op=0 throughout.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared constants for the ALU arbiter: FSM state encoding and default widths.
package alu_arb_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int OP_W_DEF   = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: grants the first set request bit found
// when scanning upward from ptr and wrapping from NREQ-1 back to 0.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt_onehot,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);

  int              idx;
  logic [NREQ-1:0] rot;

  // Scan from the farthest offset down so the nearest request after ptr wins.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path can infer a latch.
    gnt_onehot = '0;
    gnt_id     = '0;
    any        = 1'b0;
    idx        = 0;
    rot        = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      rot = req >> idx;
      if (rot[0]) begin
        gnt_onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
        gnt_id     = ID_W'(idx);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end for one shared ALU: accepts a single request, issues it
// to the ALU for one cycle, and holds the registered result until it is consumed.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter int NREQ   = 2,
  parameter int ID_W   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  input  logic [NREQ*OP_W-1:0]   req_op,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [DATA_W-1:0]      rsp_y,
  output logic                   rsp_flag,
  output logic [DATA_W-1:0]      alu_a,
  output logic [DATA_W-1:0]      alu_b,
  output logic [OP_W-1:0]        alu_op,
  output logic                   alu_rst,
  input  logic [DATA_W-1:0]      alu_y,
  input  logic                   alu_flag,
  output logic                   busy
);

  logic [1:0]        state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   lat_id;
  logic [DATA_W-1:0] lat_a;
  logic [DATA_W-1:0] lat_b;
  logic [OP_W-1:0]   lat_op;
  logic [NREQ-1:0]   gnt_onehot;
  logic [ID_W-1:0]   gnt_id;
  logic              any_req;
  logic              accept;

  rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .req        (req_valid),
    .ptr        (rr_ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_id     (gnt_id),
    .any        (any_req)
  );

  // Grants are offered only in IDLE and never while reset is asserted.
  assign accept    = (state == S_IDLE) && any_req && !rst;
  assign req_ready = accept ? gnt_onehot : '0;
  assign alu_rst   = rst;
  assign busy      = (state != S_IDLE);

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (state == S_EXEC) begin
      alu_a  = lat_a;
      alu_b  = lat_b;
      alu_op = lat_op;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      lat_id    <= '0;
      lat_a     <= '0;
      lat_b     <= '0;
      lat_op    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= '0;
      rsp_flag  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_id <= gnt_id;
            lat_a  <= req_a[gnt_id*DATA_W +: DATA_W];
            lat_b  <= req_b[gnt_id*DATA_W +: DATA_W];
            lat_op <= req_op[gnt_id*OP_W +: OP_W];
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_y     <= alu_y;
          rsp_flag  <= alu_flag;
          rsp_id    <= lat_id;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= (lat_id == ID_W'(NREQ - 1)) ? '0 : lat_id + 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
